hazard_scoreboard: RTL and testbench

- Decode-side companion to the ID/EX stage register; it decides what the ID stage may hand to ID/EX.
- Tracks destination registers of in-flight instructions in EX, MEM and WB with an internal shift pipeline that mirrors the downstream stage registers.
- Asserts stall, freezing PC and IF/ID and injecting a bubble into ID/EX, whenever a decoding instruction reads a register still pending write.
- No forwarding exists in the pipeline, so the scoreboard is the sole RAW-hazard resolver.

---
 rtl/hazard_scoreboard_if.sv | 31 +++
 rtl/hazard_scoreboard.sv | 79 +++++++
 tb/tb_hazard_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side scoreboard bundle: ID-stage request fields plus the
// stall/bubble decision and scoreboard status returned to the pipeline.
interface hazard_scoreboard_if #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             use_rs;
  logic             use_rt;
  logic [4:0]       id_rw;
  logic             id_reg_write;
  logic             flush;
  logic             stall;
  logic             bubble;
  logic [DEPTH-1:0] pend_valid;
  logic [CNT_W-1:0] stall_cnt;

  // Decode stage side: presents the instruction, receives the decision.
  modport master (
    output id_valid, rs, rt, use_rs, use_rt, id_rw, id_reg_write, flush,
    input  stall, bubble, pend_valid, stall_cnt
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, rs, rt, use_rs, use_rt, id_rw, id_reg_write, flush,
    output stall, bubble, pend_valid, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard for a pipeline without forwarding. Tracks the
// destination register of each instruction in the DEPTH post-ID stages
// (slot 0 = EX, slot DEPTH-1 = WB) and stalls the decoding instruction
// while any of its sources is still pending write.
// Optional: define HAZARD_WB_SPLIT_EN when the register file writes in the
// first half-cycle and reads in the second; the WB slot then no longer
// causes a hazard but is still tracked and reported.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input logic                i_clock,
  input logic                i_reset,   // active low, asynchronous
  hazard_scoreboard_if.slave sb
);

`ifdef HAZARD_WB_SPLIT_EN
  localparam int NCMP = DEPTH - 1;
`else
  localparam int NCMP = DEPTH;
`endif

  logic [DEPTH-1:0] r_v;
  logic [4:0]       r_rd [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic w_hit_rs;
  logic w_hit_rt;
  logic w_stall;
  logic w_load;

  // Compare both sources against every slot that can still cause a hazard.
  always_comb begin
    w_hit_rs = 1'b0;
    w_hit_rt = 1'b0;
    for (int i = 0; i < NCMP; i++) begin
      if (r_v[i] && (r_rd[i] == sb.rs)) w_hit_rs = 1'b1;
      if (r_v[i] && (r_rd[i] == sb.rt)) w_hit_rt = 1'b1;
    end
    // r0 is hardwired; it is never pending.
    if (sb.rs == 5'd0) w_hit_rs = 1'b0;
    if (sb.rt == 5'd0) w_hit_rt = 1'b0;
  end

  // Gating with reset makes stall/bubble fall immediately on reset assertion.
  assign w_stall = i_reset & sb.id_valid & ~sb.flush &
                   ((sb.use_rs & w_hit_rs) | (sb.use_rt & w_hit_rt));

  // Stalled or flushed instructions enter ID/EX as bubbles: nothing recorded.
  assign w_load = sb.id_valid & sb.id_reg_write & ~w_stall & ~sb.flush &
                  (sb.id_rw != 5'd0);

  // Slot pipeline mirroring EX/MEM/WB; the oldest entry drops off past WB.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) r_rd[i] <= 5'd0;
    end else begin
      r_v     <= (r_v << 1) | DEPTH'(w_load);
      r_rd[0] <= sb.id_rw;
      for (int i = 1; i < DEPTH; i++) r_rd[i] <= r_rd[i-1];
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign sb.stall      = w_stall;
  assign sb.bubble     = i_reset & (w_stall | sb.flush);
  assign sb.pend_valid = r_v;
  assign sb.stall_cnt  = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations,
// then randomized traffic. A timing model (per-register "ready cycle" plus a
// record of the cycles on which a write was accepted) predicts the outputs
// and is compared against the DUT on every falling clock edge.
module tb_hazard_scoreboard;
  localparam int DEPTH = 3;
  localparam int CNT_W = 10;
`ifdef HAZARD_WB_SPLIT_EN
  localparam int NCMP = DEPTH - 1;
  localparam int EXP_B2B = 2;
  localparam int EXP_K2 = 1;
  localparam int EXP_PFREE = 4;
`else
  localparam int NCMP = DEPTH;
  localparam int EXP_B2B = 3;
  localparam int EXP_K2 = 2;
  localparam int EXP_PFREE = 0;
`endif
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  hazard_scoreboard_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) sb();

  hazard_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clock (clock),
    .i_reset (rst_n),
    .sb      (sb)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_cyc = 0;
  longint m_ready [32];
  bit     m_wrote [longint];
  longint m_cnt = 0;

  task automatic m_clear();
    for (int r = 0; r < 32; r++) m_ready[r] = 0;
    m_wrote.delete();
    m_cnt = 0;
  endtask

  function automatic bit m_hit(input logic [4:0] s);
    return (s != 5'd0) && (m_cyc < m_ready[s]);
  endfunction

  function automatic bit m_stall();
    return rst_n && sb.id_valid && !sb.flush &&
           ((sb.use_rs && m_hit(sb.rs)) || (sb.use_rt && m_hit(sb.rt)));
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_clear();
    end else begin
      bit st;
      st = m_stall();
      if (sb.id_valid && sb.id_reg_write && !st && !sb.flush && sb.id_rw != 5'd0) begin
        m_ready[sb.id_rw] = m_cyc + NCMP + 1;
        m_wrote[m_cyc] = 1'b1;
      end
      if (st && m_cnt < CMAX) m_cnt++;
      m_cyc++;
    end
  end

  always @(negedge clock) begin
    logic [DEPTH-1:0] ep;
    ep = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rst_n && m_wrote.exists(m_cyc - 1 - i)) ep[i] = 1'b1;
    check("model_stall",  32'(sb.stall),      32'(m_stall()));
    check("model_bubble", 32'(sb.bubble),     32'(rst_n && (m_stall() || sb.flush)));
    check("model_pend",   32'(sb.pend_valid), 32'(ep));
    check("model_cnt",    32'(sb.stall_cnt),  32'(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input logic [4:0] rw,
                       input bit we, input bit fl);
    sb.id_valid = v; sb.rs = rs; sb.rt = rt; sb.use_rs = urs; sb.use_rt = urt;
    sb.id_rw = rw; sb.id_reg_write = we; sb.flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clock);
    #3 rst_n = 1'b0;
    @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  // Holds the current ID instruction until stall drops; ends at the falling
  // edge of the first free cycle.
  task automatic hold(output int n, output logic [DEPTH-1:0] p0, output logic [DEPTH-1:0] p1);
    n = 0; p0 = '0; p1 = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (!sb.stall) break;
      if (n == 0) p0 = sb.pend_valid;
      if (n == 1) p1 = sb.pend_valid;
      n++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int iters;
    logic [DEPTH-1:0] p0, p1;
    m_clear();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;

    // idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("t1_stall",  32'(sb.stall), 0);
      check("t1_bubble", 32'(sb.bubble), 0);
      check("t1_pend",   32'(sb.pend_valid), 0);
      check("t1_cnt",    32'(sb.stall_cnt), 0);
      step();
    end

    // back-to-back dependency on r5
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    @(negedge clock);
    check("t2_writer_stall", 32'(sb.stall), 0);
    step();
    drive(1, 5, 0, 1, 0, 0, 0, 0);
    hold(n, p0, p1);
    check("t2_stall_cycles", 32'(n), EXP_B2B);
    check("t2_pend_first",   32'(p0), 1);
    check("t2_pend_second",  32'(p1), 2);
    check("t2_pend_free",    32'(sb.pend_valid), EXP_PFREE);
    check("t2_cnt",          32'(sb.stall_cnt), EXP_B2B);
    step();
    idle();

    // producer two ahead, read through rt
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    step();
    drive(1, 1, 0, 0, 0, 6, 1, 0);
    step();
    drive(1, 0, 5, 0, 1, 0, 0, 0);
    hold(n, p0, p1);
    check("t3_stall_cycles", 32'(n), EXP_K2);
    check("t3_cnt",          32'(sb.stall_cnt), EXP_K2);
    step();
    idle();

    // r0 never pending
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("t4_stall", 32'(sb.stall), 0);
      check("t4_pend",  32'(sb.pend_valid), 0);
      step();
    end
    idle();

    // flush beats stall, nothing recorded, r7 keeps draining
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 0);
    step();
    drive(1, 7, 7, 1, 1, 9, 1, 1);
    @(negedge clock);
    check("t5_stall",  32'(sb.stall), 0);
    check("t5_bubble", 32'(sb.bubble), 1);
    check("t5_pend0",  32'(sb.pend_valid), 1);
    step();
    idle();
    @(negedge clock);
    check("t5_pend1", 32'(sb.pend_valid), 2);
    step();
    @(negedge clock);
    check("t5_pend2", 32'(sb.pend_valid), 4);
    step();

    // asynchronous reset mid-stall with the producer in MEM
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    step();
    drive(1, 5, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    check("t6_stall_ex", 32'(sb.stall), 1);
    step();
    @(negedge clock);
    check("t6_stall_mem", 32'(sb.stall), 1);
    check("t6_pend_mem",  32'(sb.pend_valid), 2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_stall",  32'(sb.stall), 0);
    check("t6_rst_bubble", 32'(sb.bubble), 0);
    check("t6_rst_pend",   32'(sb.pend_valid), 0);
    check("t6_rst_cnt",    32'(sb.stall_cnt), 0);
    @(posedge clock);
    #1 rst_n = 1'b1;
    @(negedge clock);
    check("t6_post_stall", 32'(sb.stall), 0);
    step();
    idle();

    // counter saturation
    do_reset();
    iters = 0;
    while (sb.stall_cnt != CNT_W'(CMAX) && iters < 1000) begin
      drive(1, 0, 0, 0, 0, 5, 1, 0);
      step();
      drive(1, 5, 0, 1, 0, 0, 0, 0);
      hold(n, p0, p1);
      step();
      iters++;
    end
    idle();
    check("t7_saturated", 32'(sb.stall_cnt), 32'(CMAX));
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    step();
    drive(1, 5, 0, 1, 0, 0, 0, 0);
    hold(n, p0, p1);
    check("t7_no_wrap", 32'(sb.stall_cnt), 32'(CMAX));
    step();
    idle();

    // randomized traffic with occasional asynchronous reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 9) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clock);
        #1 rst_n = 1'b1;
      end else begin
        step();
      end
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
